way_hit_encoder: RTL and testbench
==================================

Name: way_hit_encoder

Overview:
- Parametrised, registered successor to the combinational 8-to-3 one-hot encoder used in the tag-compare path of the phased cache.
- Converts a WAYS-wide tag-match vector into a way index.
- Adds a priority-resolve mode, miss and multi-hit flags, and a saturating multi-hit error counter.
- Sits between the tag-compare stage and the data-array read stage, with a valid/ready handshake on both sides.

Parameters:
- WAYS, 8, number of cache ways (width of hit vector); legal values 2..64.
- IDX_W, $clog2(WAYS), width of the way index output.
- CNT_W, 8, width of the multi-hit error counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- in_valid  input  1  hit_vec/mode valid this cycle.
- in_ready  output  1  block can accept a vector this cycle.
- hit_vec  input  WAYS  tag-match vector, bit i = way i matched.
- mode  input  1  0 = strict one-hot, 1 = priority (lowest index wins); sampled with hit_vec.
- out_valid  output  1  result registers hold a valid result.
- out_ready  input  1  downstream consumes result this cycle.
- out_idx  output  IDX_W  encoded way index.
- out_hit  output  1  result is a usable hit.
- out_miss  output  1  hit_vec was all zero.
- out_multi  output  1  hit_vec had more than one bit set.
- err_clr  input  1  synchronous clear of err_cnt.
- err_cnt  output  CNT_W  count of accepted multi-hit vectors, saturating.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid, out_idx, out_hit, out_miss, out_multi and err_cnt all go to 0. in_ready is 1 after reset.
- Reset mid-transfer: an in-flight result is discarded. No partial output is held after rst_n rises.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational, one-entry pipeline).
  - Accept occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: exactly 1 cycle. A vector accepted at edge N appears on the outputs with out_valid = 1 after edge N.
- Throughput: 1 vector per cycle when out_ready is held high.
- On edge with accept: all result registers load from the new vector; out_valid becomes 1.
- On edge with output transfer and no accept: out_valid becomes 0. out_idx and the flags keep their last values, which are don't-care.
- Backpressure: while out_valid && !out_ready, all out_* registers hold stable and in_ready = 0.
- Encoding, with popcount = number of set bits in hit_vec:
  - popcount = 0: out_idx = 0, out_hit = 0, out_miss = 1, out_multi = 0 (both modes).
  - popcount = 1: out_idx = position of the set bit, out_hit = 1, out_miss = 0, out_multi = 0 (both modes).
  - popcount > 1, mode = 0: out_idx = 0, out_hit = 0, out_miss = 0, out_multi = 1. Forcing index 0 prevents a junk index.
  - popcount > 1, mode = 1: out_idx = lowest set bit position, out_hit = 1, out_miss = 0, out_multi = 1.
- Exactly one of out_hit/out_miss is 1, except in strict-mode multi-hit where both are 0.
- err_cnt:
  - Increments by 1 on each accept whose vector has popcount > 1, in either mode.
  - Saturates at 2^CNT_W-1; no wrap.
  - err_clr = 1 at an edge sets err_cnt to 0.
  - When clear and increment coincide, clear wins and the result is 0.
  - err_cnt is independent of out_ready.
- in_valid with in_ready = 0: no state change and no count. Upstream must hold hit_vec and mode stable until accepted.
- WAYS not a power of two: out_idx never exceeds WAYS-1.
- Implementation: no latches; all outputs are flops except in_ready.

Test Plan:
- Reset: rst_n low for 3 cycles mid-stream with out_valid = 1 -> out_valid = 0, err_cnt = 0, in_ready = 1 immediately, asynchronously.
- One-hot sweep, WAYS = 8, mode 0, out_ready = 1:
  - hit_vec = 8'h01, 8'h02 … 8'h80 on consecutive cycles -> out_idx = 0..7 one cycle later, out_hit = 1, back-to-back with no bubbles.
- Miss and multi-hit, mode 0:
  - hit_vec = 8'h00 -> out_miss = 1, out_idx = 0.
  - hit_vec = 8'h24 -> out_multi = 1, out_hit = 0, out_idx = 0, err_cnt 0 -> 1.
- Priority mode: hit_vec = 8'hA8 with mode = 1 -> out_idx = 3, out_hit = 1, out_multi = 1, err_cnt increments.
- Backpressure:
  - Accept 8'h10, then hold out_ready = 0 for 4 cycles while in_valid = 1 with 8'h40 -> out_idx stays 4 and in_ready = 0 throughout.
  - Raise out_ready -> 8'h40 accepted the same cycle, out_idx = 6 next cycle.
- Counter saturation and clear, CNT_W = 2:
  - Accept 5 multi-hit vectors -> err_cnt = 3, held.
  - Assert err_clr on the same edge as a multi-hit accept -> err_cnt = 0.

Source files
------------

// File: rtl/way_hit_encoder.sv
// ============================================================================
// Module      : way_hit_encoder
// Description : Registered WAYS-to-index hit encoder with strict/priority
//               modes, miss and multi-hit flags, and a saturating error count.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module way_hit_encoder #(
    parameter int WAYS  = 8,
    parameter int IDX_W = $clog2(WAYS),
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WAYS-1:0]  hit_vec,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_hit,
    output logic             out_miss,
    output logic             out_multi,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

    logic             r_valid;
    logic [IDX_W-1:0] r_idx;
    logic             r_hit;
    logic             r_miss;
    logic             r_multi;
    logic [CNT_W-1:0] r_cnt;

    logic             w_accept;
    logic             w_xfer;
    logic             w_any;
    logic             w_multi;
    logic [IDX_W-1:0] w_low;
    logic [IDX_W-1:0] w_idx;
    logic             w_hit;

    assign in_ready = !r_valid || out_ready;
    assign w_accept = in_valid && in_ready;
    assign w_xfer   = r_valid && out_ready;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign w_any   = |hit_vec;
    assign w_multi = |(hit_vec & (hit_vec - WAYS'(1)));

    always_comb begin
        w_low = '0;
        for (int i = WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                w_low = IDX_W'(i);
            end
        end
    end

    // Strict-mode multi-hit forces index 0 so no junk index reaches the data array.
    assign w_hit = w_any && (!w_multi || mode);
    assign w_idx = w_hit ? w_low : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_hit   <= 1'b0;
            r_miss  <= 1'b0;
            r_multi <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_idx   <= w_idx;
            r_hit   <= w_hit;
            r_miss  <= !w_any;
            r_multi <= w_multi;
        end else if (w_xfer) begin
            r_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (err_clr) begin
            r_cnt <= '0;
        end else if (w_accept && w_multi && (r_cnt != C_CNT_MAX)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_valid;
    assign out_idx   = r_idx;
    assign out_hit   = r_hit;
    assign out_miss  = r_miss;
    assign out_multi = r_multi;
    assign err_cnt   = r_cnt;

endmodule

`default_nettype wire

// File: tb/tb_way_hit_encoder.sv
// ============================================================================
// Module      : tb_way_hit_encoder
// Description : Self-checking bench for way_hit_encoder (WAYS=8/CNT_W=2 and
//               WAYS=6/CNT_W=8 instances sharing one handshake).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_way_hit_encoder;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] hit_vec;
    logic       mode;
    logic       out_ready;
    logic       err_clr;

    logic       in_ready,  b_in_ready;
    logic       out_valid, b_out_valid;
    logic [2:0] out_idx,   b_out_idx;
    logic       out_hit,   b_out_hit;
    logic       out_miss,  b_out_miss;
    logic       out_multi, b_out_multi;
    logic [1:0] err_cnt;
    logic [7:0] b_err_cnt;

    int tests = 0;
    int fails = 0;

    // Reference state: one pipeline entry, shared handshake, per-instance results.
    bit m_valid;
    int m_idx, m_cnt, b_idx, b_cnt;
    bit m_hit, m_miss, m_multi, b_hit, b_miss, b_multi;

    way_hit_encoder #(.WAYS(8), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .hit_vec(hit_vec), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
        .out_idx(out_idx), .out_hit(out_hit), .out_miss(out_miss), .out_multi(out_multi),
        .err_clr(err_clr), .err_cnt(err_cnt)
    );

    way_hit_encoder #(.WAYS(6), .CNT_W(8)) dut6 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
        .hit_vec(hit_vec[5:0]), .mode(mode), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_idx(b_out_idx), .out_hit(b_out_hit), .out_miss(b_out_miss), .out_multi(b_out_multi),
        .err_clr(err_clr), .err_cnt(b_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic enc(input logic [7:0] v, input int w, input logic md,
                       output int idx, output bit h, output bit mi, output bit mu,
                       output int pc);
        int low;
        pc  = 0;
        low = -1;
        for (int i = 0; i < w; i++) begin
            if (v[i]) begin
                pc++;
                if (low < 0) low = i;
            end
        end
        mi  = (pc == 0);
        mu  = (pc > 1);
        h   = (pc == 1) || (pc > 1 && md);
        idx = h ? low : 0;
    endtask

    task automatic model_reset();
        m_valid = 0;
        m_idx = 0; m_hit = 0; m_miss = 0; m_multi = 0; m_cnt = 0;
        b_idx = 0; b_hit = 0; b_miss = 0; b_multi = 0; b_cnt = 0;
    endtask

    // Advance one clock; model sees the inputs present at the edge.
    task automatic tick();
        bit acc, clr, ha, ma, ua, hb, mb, ub;
        int ia, ib, pa, pb;
        acc = in_valid && (!m_valid || out_ready);
        clr = err_clr;
        enc(hit_vec, 8, mode, ia, ha, ma, ua, pa);
        enc({2'b00, hit_vec[5:0]}, 6, mode, ib, hb, mb, ub, pb);
        @(posedge clk);
        #1;
        if (acc) begin
            m_valid = 1;
            m_idx = ia; m_hit = ha; m_miss = ma; m_multi = ua;
            b_idx = ib; b_hit = hb; b_miss = mb; b_multi = ub;
        end else if (m_valid && out_ready) begin
            m_valid = 0;
        end
        if (clr) begin
            m_cnt = 0;
            b_cnt = 0;
        end else if (acc) begin
            if (pa > 1 && m_cnt < 3)   m_cnt++;
            if (pb > 1 && b_cnt < 255) b_cnt++;
        end
    endtask

    task automatic test_reset();
        rst_n = 0; in_valid = 0; hit_vec = '0; mode = 0; out_ready = 0; err_clr = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || err_cnt !== 2'd0) begin
            fails++; $display("FAIL reset_init: valid=%b ready=%b cnt=%0d want 0 1 0", out_valid, in_ready, err_cnt); end
        tests++; if ({out_idx, out_hit, out_miss, out_multi} !== 6'b0) begin
            fails++; $display("FAIL reset_regs: got %h want 0", {out_idx, out_hit, out_miss, out_multi}); end
        rst_n = 1;
        in_valid = 1; hit_vec = 8'h24;
        tick();
        in_valid = 0;
        tests++; if (out_valid !== 1'b1 || err_cnt !== 2'(m_cnt)) begin
            fails++; $display("FAIL reset_prefill: valid=%b cnt=%0d want 1 %0d", out_valid, err_cnt, m_cnt); end
        #3 rst_n = 0;
        model_reset();
        #1;
        tests++; if (out_valid !== 1'b0 || err_cnt !== 2'd0 || in_ready !== 1'b1 || b_out_valid !== 1'b0 || b_err_cnt !== 8'd0) begin
            fails++; $display("FAIL reset_async: valid=%b cnt=%0d ready=%b want 0 0 1", out_valid, err_cnt, in_ready); end
        repeat (3) @(posedge clk);
        #1 rst_n = 1;
        tick();
        tests++; if (out_valid !== 1'b0 || err_cnt !== 2'd0) begin
            fails++; $display("FAIL reset_release: valid=%b cnt=%0d want 0 0", out_valid, err_cnt); end
    endtask

    task automatic test_onehot_sweep();
        mode = 0; out_ready = 1; in_valid = 1;
        for (int i = 0; i < 8; i++) begin
            hit_vec = 8'(1 << i);
            tick();
            tests++; if (out_valid !== 1'b1 || out_idx !== 3'(m_idx) || out_hit !== m_hit || in_ready !== 1'b1) begin
                fails++; $display("FAIL sweep_%0d: valid=%b idx=%0d hit=%b ready=%b want 1 %0d %b 1",
                                  i, out_valid, out_idx, out_hit, in_ready, m_idx, m_hit); end
            tests++; if (b_out_idx !== 3'(b_idx) || b_out_miss !== b_miss) begin
                fails++; $display("FAIL sweep6_%0d: idx=%0d miss=%b want %0d %b", i, b_out_idx, b_out_miss, b_idx, b_miss); end
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_miss_multi();
        mode = 0; out_ready = 1; in_valid = 1; hit_vec = 8'h00;
        tick();
        tests++; if ({out_idx, out_hit, out_miss, out_multi} !== {3'(m_idx), m_hit, m_miss, m_multi}) begin
            fails++; $display("FAIL miss: got %h want %h", {out_idx, out_hit, out_miss, out_multi}, {3'(m_idx), m_hit, m_miss, m_multi}); end
        hit_vec = 8'h24;
        tick();
        in_valid = 0;
        tests++; if ({out_idx, out_hit, out_miss, out_multi} !== {3'(m_idx), m_hit, m_miss, m_multi}) begin
            fails++; $display("FAIL multi_strict: got %h want %h", {out_idx, out_hit, out_miss, out_multi}, {3'(m_idx), m_hit, m_miss, m_multi}); end
        tests++; if (err_cnt !== 2'(m_cnt) || b_err_cnt !== 8'(b_cnt)) begin
            fails++; $display("FAIL multi_cnt: got %0d/%0d want %0d/%0d", err_cnt, b_err_cnt, m_cnt, b_cnt); end
        tick();
    endtask

    task automatic test_priority();
        mode = 1; out_ready = 1; in_valid = 1; hit_vec = 8'hA8;
        tick();
        in_valid = 0; mode = 0;
        tests++; if ({out_idx, out_hit, out_miss, out_multi} !== {3'(m_idx), m_hit, m_miss, m_multi}) begin
            fails++; $display("FAIL priority: got %h want %h", {out_idx, out_hit, out_miss, out_multi}, {3'(m_idx), m_hit, m_miss, m_multi}); end
        tests++; if (err_cnt !== 2'(m_cnt) || b_out_idx !== 3'(b_idx)) begin
            fails++; $display("FAIL priority_cnt: cnt=%0d idx6=%0d want %0d %0d", err_cnt, b_out_idx, m_cnt, b_idx); end
        tick();
    endtask

    task automatic test_backpressure();
        out_ready = 0; in_valid = 1; mode = 0; hit_vec = 8'h10;
        tick();
        hit_vec = 8'h40;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++; if (out_valid !== 1'b1 || out_idx !== 3'(m_idx) || in_ready !== 1'b0 || b_in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold_%0d: valid=%b idx=%0d ready=%b want 1 %0d 0", i, out_valid, out_idx, in_ready, m_idx); end
        end
        out_ready = 1;
        #1;
        tests++; if (in_ready !== 1'b1) begin
            fails++; $display("FAIL bp_release_ready: got %b want 1", in_ready); end
        tick();
        in_valid = 0;
        tests++; if (out_valid !== 1'b1 || out_idx !== 3'(m_idx) || out_hit !== m_hit || b_out_miss !== b_miss) begin
            fails++; $display("FAIL bp_release: valid=%b idx=%0d hit=%b miss6=%b want 1 %0d %b %b",
                              out_valid, out_idx, out_hit, b_out_miss, m_idx, m_hit, b_miss); end
        tick();
    endtask

    task automatic test_saturation();
        err_clr = 1; in_valid = 0; out_ready = 1;
        tick();
        err_clr = 0;
        tests++; if (err_cnt !== 2'(m_cnt) || b_err_cnt !== 8'(b_cnt)) begin
            fails++; $display("FAIL sat_clear: got %0d/%0d want %0d/%0d", err_cnt, b_err_cnt, m_cnt, b_cnt); end
        in_valid = 1; hit_vec = 8'hFF; mode = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            tests++; if (err_cnt !== 2'(m_cnt) || b_err_cnt !== 8'(b_cnt)) begin
                fails++; $display("FAIL sat_%0d: got %0d/%0d want %0d/%0d", i, err_cnt, b_err_cnt, m_cnt, b_cnt); end
        end
        err_clr = 1;
        tick();
        err_clr = 0;
        tests++; if (err_cnt !== 2'(m_cnt) || b_err_cnt !== 8'(b_cnt)) begin
            fails++; $display("FAIL clr_wins: got %0d/%0d want %0d/%0d", err_cnt, b_err_cnt, m_cnt, b_cnt); end
        tick();
        in_valid = 0;
        tests++; if (err_cnt !== 2'(m_cnt)) begin
            fails++; $display("FAIL clr_then_inc: got %0d want %0d", err_cnt, m_cnt); end
        tick();
    endtask

    task automatic test_random();
        bit pend;
        for (int n = 0; n < 400; n++) begin
            pend = in_valid && !(!m_valid || out_ready);
            if (!pend) begin
                in_valid = ($urandom_range(0, 3) != 0);
                mode     = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 3))
                    0:       hit_vec = 8'h00;
                    1:       hit_vec = 8'(1 << $urandom_range(0, 7));
                    2:       hit_vec = 8'($urandom);
                    default: hit_vec = 8'($urandom & $urandom);
                endcase
            end
            out_ready = ($urandom_range(0, 2) != 0);
            err_clr   = ($urandom_range(0, 15) == 0);
            tick();
            #1;
            tests++; if (out_valid !== m_valid || b_out_valid !== m_valid || in_ready !== (!m_valid || out_ready)
                         || b_in_ready !== (!m_valid || out_ready)) begin
                fails++; $display("FAIL rnd_hs_%0d: valid=%b/%b ready=%b/%b want %b %b", n, out_valid, b_out_valid,
                                  in_ready, b_in_ready, m_valid, !m_valid || out_ready); end
            tests++; if (err_cnt !== 2'(m_cnt) || b_err_cnt !== 8'(b_cnt)) begin
                fails++; $display("FAIL rnd_cnt_%0d: got %0d/%0d want %0d/%0d", n, err_cnt, b_err_cnt, m_cnt, b_cnt); end
            if (m_valid) begin
                tests++; if ({out_idx, out_hit, out_miss, out_multi} !== {3'(m_idx), m_hit, m_miss, m_multi}
                             || {b_out_idx, b_out_hit, b_out_miss, b_out_multi} !== {3'(b_idx), b_hit, b_miss, b_multi}) begin
                    fails++; $display("FAIL rnd_res_%0d: got %h/%h want %h/%h", n,
                                      {out_idx, out_hit, out_miss, out_multi}, {b_out_idx, b_out_hit, b_out_miss, b_out_multi},
                                      {3'(m_idx), m_hit, m_miss, m_multi}, {3'(b_idx), b_hit, b_miss, b_multi}); end
            end
        end
        in_valid = 0; err_clr = 0; out_ready = 1;
        tick();
    endtask

    initial begin
        test_reset();
        test_onehot_sweep();
        test_miss_multi();
        test_priority();
        test_backpressure();
        test_saturation();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
